// File: rtl/lcd_fb_ram.sv
// 1-bit-per-pixel LCD framebuffer: registered pump pixel port plus a byte-wide
// host command port (set pointer, write, read, bulk fill).
module lcd_fb_ram #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 80,
  parameter int FB_BYTES = FB_W * FB_H / 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [13:0] pixeladdr_i,
  output logic        pixel_o,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [10:0] cmd_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        busy
);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [10:0] r_ptr, w_ptr_nxt;
  logic [10:0] r_idx, w_idx_nxt;
  logic [7:0]  r_fill, w_fill_nxt;
  logic        w_we;
  logic [10:0] w_waddr;
  logic [7:0]  w_wdata;
  logic        w_rd;
  logic        w_pix_ok;
  logic        r_pixel;
  logic        r_rd_valid;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_mem [0:FB_BYTES-1];

  function automatic logic [10:0] ptr_inc(input logic [10:0] p);
    return (p == 11'(FB_BYTES - 1)) ? 11'd0 : p + 11'd1;
  endfunction

  assign w_pix_ok  = (pixeladdr_i < 14'(FB_W * FB_H));
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_FILL);
  assign pixel_o   = r_pixel;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

  // Command decode and fill sequencing; the single write port is shared by host and fill.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_fill_nxt  = r_fill;
    w_we        = 1'b0;
    w_waddr     = r_ptr;
    w_wdata     = cmd_data[7:0];
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'd0: w_ptr_nxt = (cmd_data < 11'(FB_BYTES)) ? cmd_data : 11'd0;
            2'd1: begin
              w_we      = 1'b1;
              w_ptr_nxt = ptr_inc(r_ptr);
            end
            2'd2: begin
              w_rd      = 1'b1;
              w_ptr_nxt = ptr_inc(r_ptr);
            end
            2'd3: begin
              w_fill_nxt  = cmd_data[7:0];
              w_idx_nxt   = 11'd0;
              w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        w_we    = 1'b1;
        w_waddr = r_idx;
        w_wdata = r_fill;
        if (r_idx == 11'(FB_BYTES - 1)) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = 11'd0;
          w_idx_nxt   = 11'd0;
        end else begin
          w_idx_nxt = r_idx + 11'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state; reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_ptr   <= 11'd0;
      r_idx   <= 11'd0;
      r_fill  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Host read return, one cycle after an accepted READ.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'd0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= r_mem[r_ptr];
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  // Pump pixel port; addresses beyond the frame read as blank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pixel <= 1'b0;
    end else begin
      r_pixel <= w_pix_ok ? r_mem[pixeladdr_i[13:3]][pixeladdr_i[2:0]] : 1'b0;
    end
  end

endmodule
